via_timer_unit: RTL and testbench

VIA_TIMER_UNIT -- requirements
Module: via_timer_unit

---
 rtl/via_pkg.sv | 26 ++
 rtl/via_timer16.sv | 62 ++++++
 rtl/via_timer_unit.sv | 169 ++++++++++++++++
 tb/tb_via_timer_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/via_pkg.sv
// via_pkg -- shared constants for the VIA timer unit.
//   Register-select codes, IFR/ACR bit positions and the IER update helper.
//   No ports; imported by via_timer16 and via_timer_unit.
package via_pkg;

    localparam logic [3:0] RS_T1C_L = 4'h4;
    localparam logic [3:0] RS_T1C_H = 4'h5;
    localparam logic [3:0] RS_T1L_L = 4'h6;
    localparam logic [3:0] RS_T1L_H = 4'h7;
    localparam logic [3:0] RS_T2C_L = 4'h8;
    localparam logic [3:0] RS_T2C_H = 4'h9;
    localparam logic [3:0] RS_ACR   = 4'hB;
    localparam logic [3:0] RS_IFR   = 4'hD;
    localparam logic [3:0] RS_IER   = 4'hE;

    localparam int IFR_T1       = 6;
    localparam int IFR_T2       = 5;
    localparam int ACR_T1_FREE  = 6;
    localparam int ACR_T2_PULSE = 5;

    // Bit 7 of the written byte selects set (1) or clear (0) of the masked bits.
    function automatic logic [6:0] ier_next(input logic [6:0] ier, input logic [7:0] wdata);
        return wdata[7] ? (ier | wdata[6:0]) : (ier & ~wdata[6:0]);
    endfunction

endpackage

// File: rtl/via_timer16.sv
// via_timer16 -- one 16-bit down-counter with load, decrement enable,
// arm flag and zero detect.
//   clk, nRESET (sync, active-low), clk_en : clocking
//   load_i, load_val_i                     : load counter and arm
//   dec_i                                  : decrement this clk_en
//   reload_i, reload_val_i                 : on underflow reload and stay armed
//   count_o, armed_o                       : current state
//   underflow_o                            : armed zero reached this clk_en
// Reset only disarms; the counter value is held through reset.
import via_pkg::*;

module via_timer16 (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        clk_en,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        dec_i,
    input  logic        reload_i,
    input  logic [15:0] reload_val_i,
    output logic [15:0] count_o,
    output logic        armed_o,
    output logic        underflow_o
);

    logic [15:0] count_q, count_d;
    logic        armed_q, armed_d;

    // A load in the same cycle wins over the underflow.
    assign underflow_o = clk_en & dec_i & armed_q & ~load_i & (count_q == 16'h0000);

    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (load_i) begin
            count_d = load_val_i;
            armed_d = 1'b1;
        end else if (dec_i) begin
            if (underflow_o && reload_i) begin
                count_d = reload_val_i;
            end else begin
                count_d = count_q - 16'd1;
            end
            if (underflow_o && !reload_i) begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            armed_q <= 1'b0;
        end else if (clk_en) begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign count_o = count_q;
    assign armed_o = armed_q;

endmodule

// File: rtl/via_timer_unit.sv
// via_timer_unit -- 6522-style VIA timer block: T1 (one-shot / free-run),
// T2 (one-shot timed, optionally PB6 pulse counting), IFR/IER/ACR.
//   clk, nRESET (sync, active-low), clk_en (phi2 strobe)
//   CS, RnW, RS[3:0], DATA_IN[7:0] : CPU bus
//   DATA_OUT[7:0]                  : combinational read data
//   PB6                            : T2 pulse source
//   nIRQ                           : active-low interrupt request
// Build option: define VIA_T2_PULSE_COUNT_EN to let ACR5=1 make T2 count
// PB6 falling edges; otherwise T2 is always timed and PB6 is ignored.
import via_pkg::*;

module via_timer_unit (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       CS,
    input  logic       RnW,
    input  logic [3:0] RS,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    input  logic       PB6,
    output logic       nIRQ
);

    logic [7:0]  t1l_lo_q, t1l_lo_d, t1l_hi_q, t1l_hi_d, t2l_lo_q, t2l_lo_d;
    logic [7:0]  acr_q, acr_d;
    logic [6:0]  ier_q, ier_d;
    logic        ifr_t1_q, ifr_t1_d, ifr_t2_q, ifr_t2_d;
    logic        wr_en, rd_en;
    logic        t1_load, t2_load, t2_dec;
    logic [15:0] t1_count, t2_count;
    logic        t1_armed, t2_armed, t1_uflow, t2_uflow;
    logic [6:0]  ifr_vec;
    logic        irq_pending;

    assign wr_en = clk_en & CS & ~RnW;
    assign rd_en = clk_en & CS & RnW;

    assign t1_load = wr_en && (RS == RS_T1C_H);
    assign t2_load = wr_en && (RS == RS_T2C_H);

`ifdef VIA_T2_PULSE_COUNT_EN
    logic pb6_q;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            pb6_q <= 1'b0;
        end else if (clk_en) begin
            pb6_q <= PB6;
        end
    end

    assign t2_dec = ~acr_q[ACR_T2_PULSE] | (pb6_q & ~PB6);

    logic unused_cfg;
    assign unused_cfg = ^{acr_q[7], acr_q[4:0], t1_armed, t2_armed};
`else
    assign t2_dec = 1'b1;

    logic unused_cfg;
    assign unused_cfg = ^{PB6, acr_q[7], acr_q[5:0], t1_armed, t2_armed};
`endif

    via_timer16 u_t1 (
        .clk          (clk),
        .nRESET       (nRESET),
        .clk_en       (clk_en),
        .load_i       (t1_load),
        .load_val_i   ({DATA_IN, t1l_lo_q}),
        .dec_i        (1'b1),
        .reload_i     (acr_q[ACR_T1_FREE]),
        .reload_val_i ({t1l_hi_q, t1l_lo_q}),
        .count_o      (t1_count),
        .armed_o      (t1_armed),
        .underflow_o  (t1_uflow)
    );

    via_timer16 u_t2 (
        .clk          (clk),
        .nRESET       (nRESET),
        .clk_en       (clk_en),
        .load_i       (t2_load),
        .load_val_i   ({DATA_IN, t2l_lo_q}),
        .dec_i        (t2_dec),
        .reload_i     (1'b0),
        .reload_val_i (16'h0000),
        .count_o      (t2_count),
        .armed_o      (t2_armed),
        .underflow_o  (t2_uflow)
    );

    // Flag set takes priority over any clear in the same cycle.
    always_comb begin
        t1l_lo_d = t1l_lo_q;
        t1l_hi_d = t1l_hi_q;
        t2l_lo_d = t2l_lo_q;
        acr_d    = acr_q;
        ier_d    = ier_q;
        ifr_t1_d = ifr_t1_q;
        ifr_t2_d = ifr_t2_q;

        if (wr_en) begin
            case (RS)
                RS_T1C_L, RS_T1L_L: t1l_lo_d = DATA_IN;
                RS_T1C_H, RS_T1L_H: t1l_hi_d = DATA_IN;
                RS_T2C_L:           t2l_lo_d = DATA_IN;
                RS_ACR:             acr_d    = DATA_IN;
                RS_IER:             ier_d    = ier_next(ier_q, DATA_IN);
                default: ;
            endcase
        end

        if ((rd_en && RS == RS_T1C_L) || t1_load ||
            (wr_en && RS == RS_IFR && DATA_IN[IFR_T1])) begin
            ifr_t1_d = 1'b0;
        end
        if ((rd_en && RS == RS_T2C_L) || t2_load ||
            (wr_en && RS == RS_IFR && DATA_IN[IFR_T2])) begin
            ifr_t2_d = 1'b0;
        end
        if (t1_uflow) begin
            ifr_t1_d = 1'b1;
        end
        if (t2_uflow) begin
            ifr_t2_d = 1'b1;
        end
    end

    // Latches are deliberately outside the reset branch.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            acr_q    <= 8'h00;
            ier_q    <= 7'h00;
            ifr_t1_q <= 1'b0;
            ifr_t2_q <= 1'b0;
        end else if (clk_en) begin
            t1l_lo_q <= t1l_lo_d;
            t1l_hi_q <= t1l_hi_d;
            t2l_lo_q <= t2l_lo_d;
            acr_q    <= acr_d;
            ier_q    <= ier_d;
            ifr_t1_q <= ifr_t1_d;
            ifr_t2_q <= ifr_t2_d;
        end
    end

    assign ifr_vec     = {ifr_t1_q, ifr_t2_q, 5'b00000};
    assign irq_pending = |(ifr_vec & ier_q);
    assign nIRQ        = ~irq_pending;

    always_comb begin
        DATA_OUT = 8'h00;
        if (CS && RnW) begin
            case (RS)
                RS_T1C_L: DATA_OUT = t1_count[7:0];
                RS_T1C_H: DATA_OUT = t1_count[15:8];
                RS_T1L_L: DATA_OUT = t1l_lo_q;
                RS_T1L_H: DATA_OUT = t1l_hi_q;
                RS_T2C_L: DATA_OUT = t2_count[7:0];
                RS_T2C_H: DATA_OUT = t2_count[15:8];
                RS_ACR:   DATA_OUT = acr_q;
                RS_IFR:   DATA_OUT = {irq_pending, ifr_vec};
                RS_IER:   DATA_OUT = {1'b1, ier_q};
                default:  DATA_OUT = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_via_timer_unit.sv
// tb_via_timer_unit -- directed bench for via_timer_unit. Each CPU read
// pushes its expected {nIRQ, DATA_OUT} into a queue; a monitor pops and
// compares whenever a read strobe is presented to the DUT.
module tb_via_timer_unit;

    logic       clk = 1'b0;
    logic       nRESET, clk_en, CS, RnW, PB6;
    logic [3:0] RS;
    logic [7:0] DATA_IN, DATA_OUT;
    logic       nIRQ;

    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [8:0] mon_exp;
    string      mon_nm;

    always #5 clk = ~clk;

    via_timer_unit dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .clk_en   (clk_en),
        .CS       (CS),
        .RnW      (RnW),
        .RS       (RS),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .PB6      (PB6),
        .nIRQ     (nIRQ)
    );

    always @(negedge clk) begin
        if (clk_en && CS && RnW && nRESET) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read rs=%h got data=%02h nirq=%b, no expectation queued",
                         RS, DATA_OUT, nIRQ);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                if ({nIRQ, DATA_OUT} === mon_exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got data=%02h nirq=%b, expected data=%02h nirq=%b",
                             mon_nm, DATA_OUT, nIRQ, mon_exp[7:0], mon_exp[8]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bus(input logic cs, input logic rnw, input logic [3:0] rs, input logic [7:0] d);
        CS = cs; RnW = rnw; RS = rs; DATA_IN = d; clk_en = 1'b1;
        @(posedge clk); #1;
        clk_en = 1'b0; CS = 1'b0; RnW = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] rs, input logic [7:0] d);
        bus(1'b1, 1'b0, rs, d);
    endtask

    task automatic rd(input logic [3:0] rs, input logic [7:0] exp_d, input logic exp_n, input string nm);
        exp_q.push_back({exp_n, exp_d});
        name_q.push_back(nm);
        bus(1'b1, 1'b1, rs, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    initial begin
        nRESET = 1'b0; clk_en = 1'b0; CS = 1'b0; RnW = 1'b1;
        RS = 4'h0; DATA_IN = 8'h00; PB6 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nRESET = 1'b1;

        // Reset state and unmapped registers
        rd(4'hD, 8'h00, 1'b1, "rst_ifr");
        rd(4'hE, 8'h80, 1'b1, "rst_ier");
        rd(4'hB, 8'h00, 1'b1, "rst_acr");
        wr(4'h3, 8'hFF);
        rd(4'h3, 8'h00, 1'b1, "rs3_zero");
        rd(4'hF, 8'h00, 1'b1, "rsF_zero");

        // T1 one-shot, latch 0x0003: flag on 4th clk_en after load
        wr(4'hE, 8'hC0);
        wr(4'h6, 8'h03);
        wr(4'h7, 8'h00);
        wr(4'h5, 8'h00);
        idle(2);
        rd(4'hD, 8'h00, 1'b1, "t1os_ifr_l3");
        rd(4'hD, 8'h00, 1'b1, "t1os_ifr_l4");
        rd(4'hD, 8'hC0, 1'b0, "t1os_ifr_l5");
        rd(4'h4, 8'hFE, 1'b0, "t1os_rd4_wrapped");
        rd(4'hD, 8'h00, 1'b1, "t1os_ifr_cleared");
        rd(4'h5, 8'hFF, 1'b1, "t1os_cnt_hi");
        rd(4'h6, 8'h03, 1'b1, "t1_latch_lo");
        rd(4'h7, 8'h00, 1'b1, "t1_latch_hi");

        // T1 free-run, latch 0x0002: 2,1,0,2,1,0; read-clear loses to set
        wr(4'hB, 8'h40);
        wr(4'h6, 8'h02);
        wr(4'h5, 8'h00);
        rd(4'h4, 8'h02, 1'b1, "t1fr_seq0");
        rd(4'h4, 8'h01, 1'b1, "t1fr_seq1");
        rd(4'h4, 8'h00, 1'b1, "t1fr_seq2_rdclr_vs_set");
        rd(4'h4, 8'h02, 1'b0, "t1fr_seq3_flag_kept");
        rd(4'h4, 8'h01, 1'b1, "t1fr_seq4");
        rd(4'h4, 8'h00, 1'b1, "t1fr_seq5");
        rd(4'hD, 8'hC0, 1'b0, "t1fr_second_flag");
        idle(1);
        wr(4'h5, 8'h00);
        rd(4'h4, 8'h02, 1'b1, "t1_load_vs_uflow_cnt");
        rd(4'hD, 8'h00, 1'b1, "t1_load_vs_uflow_ifr");
        wr(4'hB, 8'h00);
        idle(4);
        wr(4'hD, 8'h60);
        wr(4'hE, 8'h40);
        rd(4'hD, 8'h00, 1'b1, "t1_cleanup_ifr");

        // T2 one-shot, load 0x0001
        wr(4'hE, 8'hA0);
        wr(4'h8, 8'h01);
        wr(4'h9, 8'h00);
        rd(4'hD, 8'h00, 1'b1, "t2_ifr_m1");
        rd(4'hD, 8'h00, 1'b1, "t2_ifr_m2");
        rd(4'h8, 8'hFF, 1'b0, "t2_cnt_ffff_flag");
        rd(4'h8, 8'hFE, 1'b1, "t2_cnt_fffe_cleared");
        rd(4'h9, 8'hFF, 1'b1, "t2_cnt_hi");
        idle(3);
        rd(4'hD, 8'h00, 1'b1, "t2_no_second_flag");

        // IER set/clear and IFR write-clear
        wr(4'h8, 8'h00);
        wr(4'h9, 8'h00);
        wr(4'hE, 8'hA0);
        rd(4'hD, 8'hA0, 1'b0, "ier_enabled_irq");
        wr(4'hE, 8'h20);
        rd(4'hD, 8'h20, 1'b1, "ier_masked_irq");
        wr(4'hD, 8'h60);
        rd(4'hD, 8'h00, 1'b1, "ifr_write_clear");
        rd(4'hE, 8'h80, 1'b1, "ier_readback");

`ifdef VIA_T2_PULSE_COUNT_EN
        // T2 pulse counting on PB6 falling edges
        wr(4'hE, 8'hA0);
        wr(4'hB, 8'h20);
        rd(4'hB, 8'h20, 1'b1, "acr_readback");
        PB6 = 1'b1;
        wr(4'h8, 8'h02);
        wr(4'h9, 8'h00);
        rd(4'h8, 8'h02, 1'b1, "pc_no_edge_hold");
        PB6 = 1'b0; idle(1);
        PB6 = 1'b1; rd(4'hD, 8'h00, 1'b1, "pc_edge1_noflag");
        PB6 = 1'b0; idle(1);
        PB6 = 1'b1; rd(4'h8, 8'h00, 1'b1, "pc_edge2_cnt0");
        PB6 = 1'b0; idle(1);
        PB6 = 1'b1; rd(4'hD, 8'hA0, 1'b0, "pc_edge3_flag");
`else
        // ACR5 stored but T2 stays timed; PB6 ignored
        wr(4'hB, 8'h20);
        rd(4'hB, 8'h20, 1'b1, "acr_readback");
        wr(4'h8, 8'h02);
        wr(4'h9, 8'h00);
        PB6 = 1'b0;
        rd(4'h8, 8'h02, 1'b1, "t2_timed_c2");
        rd(4'h8, 8'h01, 1'b1, "t2_timed_c1");
        rd(4'hD, 8'h00, 1'b1, "t2_timed_c0");
        rd(4'hD, 8'h20, 1'b1, "t2_timed_flag");
        PB6 = 1'b1;
`endif

        // Reset mid-count: disarms, clears flags, keeps counter and latches
        wr(4'hB, 8'h00);
        wr(4'hE, 8'hC0);
        wr(4'h6, 8'h05);
        wr(4'h5, 8'h00);
        idle(1);
        nRESET = 1'b0; clk_en = 1'b1; CS = 1'b0;
        @(posedge clk); #1;
        nRESET = 1'b1; clk_en = 1'b0;
        @(posedge clk); #1;
        rd(4'h4, 8'h04, 1'b1, "rst_cnt_held");
        idle(5);
        rd(4'hD, 8'h00, 1'b1, "rst_no_flag");
        rd(4'hE, 8'h80, 1'b1, "rst_ier_mid");
        rd(4'hB, 8'h00, 1'b1, "rst_acr_mid");
        rd(4'h6, 8'h05, 1'b1, "rst_latch_lo");
        rd(4'h7, 8'h00, 1'b1, "rst_latch_hi");

        idle(2);
        n_chk++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
